// File: rtl/mmu_pkg.sv
// Shared encodings and lane helpers for the banked data/instruction MMU.
package mmu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [1:0] FC_NONE       = 2'd0;
  localparam logic [1:0] FC_MISALIGN   = 2'd1;
  localparam logic [1:0] FC_UNMAPPED   = 2'd2;
  localparam logic [1:0] FC_IO_TIMEOUT = 2'd3;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef enum logic {IDLE, IO_WAIT} state_e;

  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: lane_be = 4'b0001 << off;
      SZ_HALF: lane_be = 4'b0011 << {off[1], 1'b0};
      default: lane_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_place(input logic [1:0] size, input logic [31:0] di);
    case (size)
      SZ_BYTE: store_place = {4{di[7:0]}};
      SZ_HALF: store_place = {2{di[15:0]}};
      default: store_place = di;
    endcase
  endfunction

  // Pick the addressed byte/half out of a full word and extend it.
  function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [1:0] off,
                                               input logic [1:0] size, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> {off, 3'b000});
    h = 16'(w >> {off[1], 4'b0000});
    case (size)
      SZ_BYTE: load_extract = {{24{sgn & b[7]}}, b};
      SZ_HALF: load_extract = {{16{sgn & h[15]}}, h};
      default: load_extract = w;
    endcase
  endfunction

endpackage

// File: rtl/mmu_byte_lane.sv
// One byte lane of the data RAM: single port, synchronous read-first.
module mmu_byte_lane #(
  parameter int unsigned DEPTH_LOG = 8
) (
  input  logic                 clk,
  input  logic                 en,
  input  logic                 we,
  input  logic [DEPTH_LOG-1:0] addr,
  input  logic [7:0]           di,
  output logic [7:0]           dout
);

  logic [7:0] mem [2**DEPTH_LOG];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= di;
      dout <= mem[addr];
    end
  end

endmodule

// File: rtl/mmu_banked.sv
// Data/instruction MMU: banked byte-lane RAM window, handshaked IO window with
// timeout, instruction ROM pass-through.
module mmu_banked
  import mmu_pkg::*;
#(
  parameter logic [31:0] RAM_BASE      = 32'h1000_0000,
  parameter int unsigned RAM_BYTES_LOG = 10,
  parameter int unsigned IM_AW         = 12,
  parameter logic [31:0] IO_BASE       = 32'h8000_0000,
  parameter int unsigned IO_AW         = 8,
  parameter int unsigned IO_TIMEOUT    = 16
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic [31:0]      im_addr,
  output logic [IM_AW-3:0] im_addr_out,
  input  logic [31:0]      im_data,
  output logic [31:0]      im_do,
  input  logic             dm_req,
  input  logic             dm_we,
  input  logic [1:0]       dm_size,
  input  logic             dm_signed,
  input  logic [31:0]      dm_addr,
  input  logic [31:0]      dm_di,
  output logic [31:0]      dm_do,
  output logic             dm_rvalid,
  output logic             dm_stall,
  output logic             dm_fault,
  output logic [1:0]       dm_fault_cause,
  output logic [IO_AW-1:0] io_addr,
  output logic             io_en,
  output logic             io_we,
  output logic [3:0]       io_be,
  output logic [31:0]      io_data_write,
  input  logic [31:0]      io_data_read,
  input  logic             io_ready
);

  localparam int unsigned LANE_LOG = RAM_BYTES_LOG - 2;
  localparam int unsigned CNT_W    = (IO_TIMEOUT > 1) ? $clog2(IO_TIMEOUT) : 1;
  localparam logic [32:0] RAM_SPAN = 33'(1) << RAM_BYTES_LOG;
  localparam logic [32:0] IO_SPAN  = 33'(1) << IO_AW;

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic             accept, misalign, ram_hit, io_hit;
  logic [31:0]      ram_off, io_off, wdata;
  logic [3:0]       be, lane_en;
  logic [31:0]      ram_q, rd_q;
  logic             rd_sel_ram;
  logic [1:0]       ld_off, ld_size;
  logic             ld_signed;
  logic             unused_im_bits;

  assign im_addr_out    = im_addr[IM_AW-1:2];
  assign unused_im_bits = ^{im_addr[31:IM_AW], im_addr[1:0]};
  assign dm_stall       = (state == IO_WAIT);
  assign dm_do          = rd_sel_ram ? load_extract(ram_q, ld_off, ld_size, ld_signed) : rd_q;

  // Request decode: alignment first, then RAM, then IO window.
  always_comb begin
    accept   = dm_req && !dm_stall;
    misalign = (dm_size == 2'd3) ||
               (dm_size == SZ_HALF && dm_addr[0]) ||
               (dm_size == SZ_WORD && dm_addr[1:0] != 2'b00);
    ram_off  = dm_addr - RAM_BASE;
    io_off   = dm_addr - IO_BASE;
    ram_hit  = (dm_addr >= RAM_BASE) && (33'(ram_off) < RAM_SPAN);
    io_hit   = (dm_addr >= IO_BASE) && (33'(io_off) < IO_SPAN);
    be       = lane_be(dm_size, dm_addr[1:0]);
    wdata    = store_place(dm_size, dm_di);
    lane_en  = (accept && !misalign && ram_hit) ? be : 4'b0000;
  end

  for (genvar i = 0; i < 4; i++) begin : g_lane
    mmu_byte_lane #(.DEPTH_LOG(LANE_LOG)) u_lane (
      .clk  (clk),
      .en   (lane_en[i]),
      .we   (dm_we),
      .addr (ram_off[RAM_BYTES_LOG-1:2]),
      .di   (wdata[8*i +: 8]),
      .dout (ram_q[8*i +: 8])
    );
  end

  always_ff @(posedge clk) begin
    if (!resetb) begin
      im_do          <= NOP_INSN;
      state          <= IDLE;
      cnt            <= '0;
      io_en          <= 1'b0;
      io_we          <= 1'b0;
      io_addr        <= '0;
      io_be          <= 4'b0000;
      io_data_write  <= 32'h0;
      dm_fault       <= 1'b0;
      dm_fault_cause <= FC_NONE;
      dm_rvalid      <= 1'b0;
      rd_sel_ram     <= 1'b0;
      rd_q           <= 32'h0;
      ld_off         <= 2'b00;
      ld_size        <= SZ_BYTE;
      ld_signed      <= 1'b0;
    end else begin
      im_do          <= im_data;
      dm_fault       <= 1'b0;
      dm_fault_cause <= FC_NONE;
      dm_rvalid      <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            ld_off    <= dm_addr[1:0];
            ld_size   <= dm_size;
            ld_signed <= dm_signed;
            if (misalign) begin
              dm_fault       <= 1'b1;
              dm_fault_cause <= FC_MISALIGN;
            end else if (ram_hit) begin
              if (!dm_we) begin
                dm_rvalid  <= 1'b1;
                rd_sel_ram <= 1'b1;
              end
            end else if (io_hit) begin
              state         <= IO_WAIT;
              cnt           <= '0;
              io_en         <= 1'b1;
              io_we         <= dm_we;
              io_addr       <= io_off[IO_AW-1:0];
              io_be         <= be;
              io_data_write <= wdata;
            end else begin
              dm_fault       <= 1'b1;
              dm_fault_cause <= FC_UNMAPPED;
            end
          end
        end
        IO_WAIT: begin
          // A ready in the same cycle as the timeout completes normally.
          if (io_ready) begin
            state <= IDLE;
            io_en <= 1'b0;
            if (!io_we) begin
              dm_rvalid  <= 1'b1;
              rd_sel_ram <= 1'b0;
              rd_q       <= load_extract(io_data_read, ld_off, ld_size, ld_signed);
            end
          end else if (IO_TIMEOUT != 0 && cnt == CNT_W'(IO_TIMEOUT - 1)) begin
            state          <= IDLE;
            io_en          <= 1'b0;
            dm_fault       <= 1'b1;
            dm_fault_cause <= FC_IO_TIMEOUT;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmu_banked.sv
// Scoreboard bench for mmu_banked: RAM, extension, faults, IO handshake/timeout, reset.
module tb_mmu_banked;
  import mmu_pkg::*;

  logic        clk, resetb;
  logic [31:0] im_addr, im_data, im_do;
  logic [9:0]  im_addr_out;
  logic        dm_req, dm_we, dm_signed, dm_rvalid, dm_stall, dm_fault;
  logic [1:0]  dm_size, dm_fault_cause;
  logic [31:0] dm_addr, dm_di, dm_do;
  logic [7:0]  io_addr;
  logic        io_en, io_we, io_ready;
  logic [3:0]  io_be;
  logic [31:0] io_data_write, io_data_read;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_q [$];

  mmu_banked dut (
    .clk(clk), .resetb(resetb), .im_addr(im_addr), .im_addr_out(im_addr_out),
    .im_data(im_data), .im_do(im_do), .dm_req(dm_req), .dm_we(dm_we),
    .dm_size(dm_size), .dm_signed(dm_signed), .dm_addr(dm_addr), .dm_di(dm_di),
    .dm_do(dm_do), .dm_rvalid(dm_rvalid), .dm_stall(dm_stall), .dm_fault(dm_fault),
    .dm_fault_cause(dm_fault_cause), .io_addr(io_addr), .io_en(io_en), .io_we(io_we),
    .io_be(io_be), .io_data_write(io_data_write), .io_data_read(io_data_read),
    .io_ready(io_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [1:0] sz, input logic sgn,
                       input logic [31:0] a, input logic [31:0] d);
    dm_req = 1'b1; dm_we = we; dm_size = sz; dm_signed = sgn; dm_addr = a; dm_di = d;
    step();
    dm_req = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] e;
    resetb = 1'b0;
    step(); step();
    checks++;
    if ({im_do, dm_do, dm_rvalid, dm_fault, dm_fault_cause, io_en, io_we, io_be, io_addr,
         io_data_write, dm_stall} !== {NOP_INSN, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 4'h0,
         8'h0, 32'h0, 1'b0}) begin
      failures++;
      $display("FAIL reset_state im_do=%h dm_do=%h rv=%b flt=%b io_en=%b stall=%b",
               im_do, dm_do, dm_rvalid, dm_fault, io_en, dm_stall);
    end
    resetb = 1'b1;
    step();
    e = 32'hCAFE_BABE;
    checks++;
    if (im_do !== e) begin
      failures++; $display("FAIL im_pass got=%h want=%h", im_do, e);
    end
    checks++;
    if (im_addr_out !== 10'h2AF) begin
      failures++; $display("FAIL im_addr_out got=%h want=2af", im_addr_out);
    end
  endtask

  task automatic test_ram_word();
    logic [31:0] e;
    drive(1'b1, SZ_WORD, 1'b0, 32'h1000_0010, 32'hDEAD_BEEF);
    checks++;
    if (dm_rvalid !== 1'b0 || dm_fault !== 1'b0) begin
      failures++; $display("FAIL store_no_rvalid rv=%b flt=%b want 0 0", dm_rvalid, dm_fault);
    end
    exp_q.push_back(32'hDEAD_BEEF);
    drive(1'b0, SZ_WORD, 1'b0, 32'h1000_0010, 32'h0);
    e = exp_q.pop_front();
    checks++;
    if (dm_rvalid !== 1'b1 || dm_do !== e) begin
      failures++; $display("FAIL ram_word rv=%b got=%h want=%h", dm_rvalid, dm_do, e);
    end
    step();
    checks++;
    if (dm_rvalid !== 1'b0) begin
      failures++; $display("FAIL rvalid_pulse got=%b want=0", dm_rvalid);
    end
    // Last word of the window, then store-word/store-half/load-word back to back.
    drive(1'b1, SZ_WORD, 1'b0, 32'h1000_03FC, 32'h0BAD_F00D);
    drive(1'b1, SZ_WORD, 1'b0, 32'h1000_0020, 32'h0);
    drive(1'b1, SZ_HALF, 1'b0, 32'h1000_0022, 32'hFFFF_5678);
    exp_q.push_back(32'h5678_0000);
    drive(1'b0, SZ_WORD, 1'b0, 32'h1000_0020, 32'h0);
    e = exp_q.pop_front();
    checks++;
    if (dm_rvalid !== 1'b1 || dm_do !== e) begin
      failures++; $display("FAIL half_store rv=%b got=%h want=%h", dm_rvalid, dm_do, e);
    end
    exp_q.push_back(32'h0BAD_F00D);
    drive(1'b0, SZ_WORD, 1'b0, 32'h1000_03FC, 32'h0);
    e = exp_q.pop_front();
    checks++;
    if (dm_rvalid !== 1'b1 || dm_do !== e) begin
      failures++; $display("FAIL ram_top rv=%b got=%h want=%h", dm_rvalid, dm_do, e);
    end
  endtask

  task automatic test_byte_ext();
    logic [1:0]  tsz [7] = '{SZ_BYTE, SZ_BYTE, SZ_WORD, SZ_HALF, SZ_HALF, SZ_BYTE, SZ_BYTE};
    logic        tsg [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [31:0] ta  [7] = '{32'h1000_0013, 32'h1000_0013, 32'h1000_0010, 32'h1000_0012,
                             32'h1000_0012, 32'h1000_0010, 32'h1000_0011};
    logic [31:0] te  [7] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h80AD_BEEF, 32'hFFFF_80AD,
                             32'h0000_80AD, 32'h0000_00EF, 32'hFFFF_FFBE};
    logic [31:0] e;
    drive(1'b1, SZ_BYTE, 1'b0, 32'h1000_0013, 32'h1234_5680);
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back(te[i]);
      drive(1'b0, tsz[i], tsg[i], ta[i], 32'h0);
      e = exp_q.pop_front();
      checks++;
      if (dm_rvalid !== 1'b1 || dm_do !== e) begin
        failures++; $display("FAIL load_ext[%0d] rv=%b got=%h want=%h", i, dm_rvalid, dm_do, e);
      end
    end
  endtask

  task automatic test_faults();
    logic [1:0]  tsz [6] = '{SZ_HALF, 2'd3, SZ_WORD, SZ_WORD, SZ_WORD, SZ_WORD};
    logic        twe [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0] ta  [6] = '{32'h1000_0011, 32'h1000_0010, 32'h1000_0012, 32'h0000_0100,
                             32'h1000_0400, 32'h8000_0100};
    logic [1:0]  tc  [6] = '{FC_MISALIGN, FC_MISALIGN, FC_MISALIGN, FC_UNMAPPED,
                             FC_UNMAPPED, FC_UNMAPPED};
    logic [31:0] e;
    for (int i = 0; i < 6; i++) begin
      drive(twe[i], tsz[i], 1'b0, ta[i], 32'h0);
      checks++;
      if (dm_fault !== 1'b1 || dm_fault_cause !== tc[i] || dm_rvalid !== 1'b0 || io_en !== 1'b0) begin
        failures++;
        $display("FAIL fault[%0d] flt=%b cause=%0d rv=%b io_en=%b want 1 %0d 0 0",
                 i, dm_fault, dm_fault_cause, dm_rvalid, io_en, tc[i]);
      end
    end
    step();
    checks++;
    if (dm_fault !== 1'b0 || dm_fault_cause !== FC_NONE) begin
      failures++; $display("FAIL fault_pulse flt=%b cause=%0d want 0 0", dm_fault, dm_fault_cause);
    end
    exp_q.push_back(32'h80AD_BEEF);
    drive(1'b0, SZ_WORD, 1'b0, 32'h1000_0010, 32'h0);
    e = exp_q.pop_front();
    checks++;
    if (dm_rvalid !== 1'b1 || dm_do !== e) begin
      failures++; $display("FAIL mem_unchanged rv=%b got=%h want=%h", dm_rvalid, dm_do, e);
    end
  endtask

  task automatic test_io_store();
    logic [31:0] e;
    drive(1'b1, SZ_WORD, 1'b0, 32'h8000_0004, 32'h1234_5678);
    // Keep a RAM load pending; it must stall until the IO access completes.
    exp_q.push_back(32'h80AD_BEEF);
    dm_req = 1'b1; dm_we = 1'b0; dm_size = SZ_WORD; dm_signed = 1'b0; dm_addr = 32'h1000_0010;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({io_en, io_we, dm_stall, dm_rvalid, io_be, io_addr, io_data_write} !==
          {1'b1, 1'b1, 1'b1, 1'b0, 4'hF, 8'h04, 32'h1234_5678}) begin
        failures++;
        $display("FAIL io_store[%0d] en=%b we=%b stall=%b rv=%b be=%h addr=%h wd=%h", k,
                 io_en, io_we, dm_stall, dm_rvalid, io_be, io_addr, io_data_write);
      end
      io_ready = (k == 3);
      step();
    end
    io_ready = 1'b0;
    checks++;
    if (io_en !== 1'b0 || dm_stall !== 1'b0 || dm_rvalid !== 1'b0 || dm_fault !== 1'b0) begin
      failures++;
      $display("FAIL io_store_done en=%b stall=%b rv=%b flt=%b", io_en, dm_stall, dm_rvalid, dm_fault);
    end
    step();
    dm_req = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (dm_rvalid !== 1'b1 || dm_do !== e) begin
      failures++; $display("FAIL after_io_load rv=%b got=%h want=%h", dm_rvalid, dm_do, e);
    end
  endtask

  task automatic test_io_load();
    logic [1:0]  tsz [2] = '{SZ_BYTE, SZ_HALF};
    logic        tsg [2] = '{1'b1, 1'b0};
    logic [31:0] ta  [2] = '{32'h8000_0002, 32'h8000_0006};
    logic [31:0] trd [2] = '{32'h00AB_0000, 32'hBEEF_0000};
    logic [3:0]  tbe [2] = '{4'b0100, 4'b1100};
    logic [7:0]  tio [2] = '{8'h02, 8'h06};
    logic [31:0] e;
    exp_q.push_back(32'hFFFF_FFAB);
    exp_q.push_back(32'h0000_BEEF);
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, tsz[i], tsg[i], ta[i], 32'h0);
      checks++;
      if ({io_en, io_we, io_be, io_addr} !== {1'b1, 1'b0, tbe[i], tio[i]}) begin
        failures++;
        $display("FAIL io_load_req[%0d] en=%b we=%b be=%h addr=%h want be=%h addr=%h",
                 i, io_en, io_we, io_be, io_addr, tbe[i], tio[i]);
      end
      io_ready = 1'b1; io_data_read = trd[i];
      step();
      io_ready = 1'b0; io_data_read = 32'h0;
      e = exp_q.pop_front();
      checks++;
      if (dm_rvalid !== 1'b1 || dm_do !== e || io_en !== 1'b0) begin
        failures++;
        $display("FAIL io_load[%0d] rv=%b got=%h want=%h io_en=%b", i, dm_rvalid, dm_do, e, io_en);
      end
    end
  endtask

  task automatic test_io_timeout();
    int n = 0;
    drive(1'b0, SZ_BYTE, 1'b0, 32'h8000_0002, 32'h0);
    while (io_en === 1'b1 && n < 100) begin
      step();
      n++;
    end
    checks++;
    if (n != 16) begin
      failures++; $display("FAIL timeout_cycles got=%0d want=16", n);
    end
    checks++;
    if (dm_fault !== 1'b1 || dm_fault_cause !== FC_IO_TIMEOUT || dm_stall !== 1'b0 ||
        dm_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL timeout_fault flt=%b cause=%0d stall=%b rv=%b want 1 3 0 0",
               dm_fault, dm_fault_cause, dm_stall, dm_rvalid);
    end
    step();
    checks++;
    if (dm_fault !== 1'b0 || io_en !== 1'b0) begin
      failures++; $display("FAIL timeout_after flt=%b io_en=%b want 0 0", dm_fault, io_en);
    end
  endtask

  task automatic test_reset_in_io();
    drive(1'b1, SZ_WORD, 1'b0, 32'h8000_0008, 32'h5555_AAAA);
    step();
    checks++;
    if (io_en !== 1'b1 || dm_stall !== 1'b1) begin
      failures++; $display("FAIL io_pending en=%b stall=%b want 1 1", io_en, dm_stall);
    end
    resetb = 1'b0;
    step();
    checks++;
    if (io_en !== 1'b0 || dm_stall !== 1'b0 || im_do !== NOP_INSN || dm_fault !== 1'b0) begin
      failures++;
      $display("FAIL reset_in_io en=%b stall=%b im_do=%h flt=%b", io_en, dm_stall, im_do, dm_fault);
    end
    resetb = 1'b1;
    step();
    checks++;
    if (dm_fault !== 1'b0 || io_en !== 1'b0 || im_do !== 32'hCAFE_BABE) begin
      failures++;
      $display("FAIL post_reset flt=%b io_en=%b im_do=%h", dm_fault, io_en, im_do);
    end
  endtask

  initial begin
    resetb = 1'b0; im_addr = 32'h0000_0ABC; im_data = 32'hCAFE_BABE;
    dm_req = 1'b0; dm_we = 1'b0; dm_size = SZ_WORD; dm_signed = 1'b0;
    dm_addr = 32'h0; dm_di = 32'h0; io_data_read = 32'h0; io_ready = 1'b0;
    test_reset();
    test_ram_word();
    test_byte_ext();
    test_faults();
    test_io_store();
    test_io_load();
    test_io_timeout();
    test_reset_in_io();
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mmu_banked.md
Name: mmu_banked

Overview:
- Parametrised successor data/instruction MMU for the RV32 core. Byte-addressable, banked RAM window, IO window with ready handshake and timeout, instruction ROM pass-through.
- Generates byte enables internally from size and address. Sign/zero-extends loads. Detects misaligned and unmapped accesses.
- Sits between the core's MEM stage and the instruction ROM, data RAM lanes and the IO bus.

Parameters:
- RAM_BASE, 32'h1000_0000, byte base address of the RAM window.
- RAM_BYTES_LOG, 10, log2 of RAM window size in bytes; each of the 4 lanes is 2^(RAM_BYTES_LOG-2) deep.
- IM_AW, 12, log2 of instruction ROM size in bytes; ROM sits at address 0.
- IO_BASE, 32'h8000_0000, byte base address of the IO window.
- IO_AW, 8, log2 of IO window size in bytes.
- IO_TIMEOUT, 16, maximum IO_WAIT cycles before a fault; 0 disables the timeout.

Ports:
- clk  in  1  clock
- resetb  in  1  reset; synchronous, active-low
- im_addr  in  32  instruction fetch address
- im_addr_out  out  IM_AW-2  word address to ROM = im_addr[IM_AW-1:2]
- im_data  in  32  ROM data
- im_do  out  32  registered instruction
- dm_req  in  1  data access request
- dm_we  in  1  store when 1, load when 0
- dm_size  in  2  0=byte, 1=half, 2=word; 3 is illegal and faults as misaligned
- dm_signed  in  1  sign-extend load
- dm_addr  in  32  data byte address
- dm_di  in  32  store data, right-aligned
- dm_do  out  32  load data, extended
- dm_rvalid  out  1  dm_do valid (loads only)
- dm_stall  out  1  request not accepted this cycle
- dm_fault  out  1  one-cycle fault pulse
- dm_fault_cause  out  2  0 none, 1 misaligned, 2 unmapped, 3 IO timeout
- io_addr  out  IO_AW  IO offset
- io_en, io_we  out  1 each  IO strobe and write
- io_be  out  4  IO lane enables
- io_data_write  out  32  lane-placed IO store data
- io_data_read  in  32  IO read data
- io_ready  in  1  IO completion

Behaviour:
- Reset (synchronous, resetb=0 at posedge) sets:
  - im_do = 32'h0000_0013 (NOP).
  - dm_do, dm_rvalid, dm_fault, dm_fault_cause, all io_* outputs and the timeout counter = 0.
  - FSM = IDLE.
  - RAM contents are not reset.
  - Reset during IO_WAIT abandons the transaction: io_en=0 after that edge, no fault raised.
- im_do <= im_data every cycle. im_addr_out is combinational.
- Accept condition: dm_req && !dm_stall. dm_stall = (state==IO_WAIT).
- Decode order for an accepted request:
  - Misaligned: half with addr[0]=1, word with addr[1:0]!=0, or size 3.
  - RAM hit: RAM_BASE <= addr < RAM_BASE + 2^RAM_BYTES_LOG.
  - IO hit: IO_BASE <= addr < IO_BASE + 2^IO_AW.
  - Otherwise unmapped. The ROM region counts as unmapped for the data port.
- Any fault:
  - No lane enable, no io_en.
  - dm_fault=1 with its cause in the next cycle; dm_rvalid=0.
- Lane enables:
  - byte: 4'b0001 << addr[1:0]
  - half: 4'b0011 << {addr[1],1'b0}
  - word: 4'b1111
- Store data placement: byte {4{di[7:0]}}, half {2{di[15:0]}}, word di.
- RAM access:
  - Only the enabled lanes are enabled; a disabled lane is never enabled or written.
  - A store commits at the accepting edge.
  - A load returns dm_do with dm_rvalid=1 one cycle later.
  - A store at T followed by a load at T+1 to the same address returns the new data.
- Load extraction: byte/half selected by the registered offset and size, then sign- or zero-extended per the registered dm_signed. Word loads pass through unchanged.
- FSM IDLE -> IO_WAIT on an accepted IO request:
  - Next cycle: io_en=1, with io_we, io_addr = addr - IO_BASE, io_be and io_data_write registered.
  - io_* outputs hold stable throughout IO_WAIT.
- In IO_WAIT:
  - io_ready=1 -> IDLE and io_en=0 next cycle. For a load, io_data_read is captured and extracted; dm_do and dm_rvalid=1 appear in the cycle after io_ready.
  - The counter increments each IO_WAIT cycle without io_ready.
  - When the counter reaches IO_TIMEOUT-1 (IO_TIMEOUT != 0): -> IDLE, io_en=0, dm_fault=1, cause=3.
  - io_ready together with the timeout in the same cycle: io_ready wins.
- dm_req=0 or a stalled request: no RAM enable and no state change. io_en is never high outside IO_WAIT.

Decomposition:
- Package mmu_pkg holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD
  - fault causes FC_NONE/FC_MISALIGN/FC_UNMAPPED/FC_IO_TIMEOUT
  - NOP_INSN constant
  - FSM state enum (IDLE, IO_WAIT)
- Sub-module mmu_byte_lane: single-port 8-bit synchronous-read RAM with en/we and parameter DEPTH_LOG, instantiated 4 times.

Test Plan:
- Store word 0xDEADBEEF at 0x1000_0010, then load word at the same address -> dm_do=0xDEADBEEF with dm_rvalid=1 one cycle later.
- Store byte 0x80 at 0x1000_0013 -> signed byte load returns 0xFFFFFF80, unsigned byte load returns 0x00000080, word load returns 0x80ADBEEF; lanes 0-2 never written.
- Half load at 0x1000_0011 -> dm_fault=1, cause=1, no lane enabled, memory unchanged. Load at 0x0000_0100 -> cause=2.
- IO store 0x12345678 to 0x8000_0004 with io_ready rising 3 cycles after io_en -> io_en/io_we high for 4 cycles, io_addr=0x04, io_be=4'b1111, dm_stall high for the same cycles, then an accepted load follows.
- IO byte load at 0x8000_0002 with io_ready held low -> dm_fault with cause=3 after 16 IO_WAIT cycles, then io_en=0 and dm_stall=0.
- resetb=0 during IO_WAIT -> next edge io_en=0, FSM IDLE, im_do=0x00000013, no fault.
